// File: rtl/imager_rx.sv
// Parallel pixel bus receiver: tags each active pixel with row/col and reports frame geometry.
// Optional per-frame checksum is built when IMAGER_RX_CHECKSUM_EN is defined.
module imager_rx #(
  parameter int DATA_WIDTH     = 10,
  parameter int NUM_ROWS_WIDTH = 12,
  parameter int NUM_COLS_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [DATA_WIDTH-1:0]     dat,
  input  logic                      fv,
  input  logic                      lv,
  output logic [DATA_WIDTH-1:0]     pix_dat,
  output logic                      pix_valid,
  output logic [NUM_ROWS_WIDTH-1:0] pix_row,
  output logic [NUM_COLS_WIDTH-1:0] pix_col,
  output logic                      pix_sof,
  output logic                      frame_done,
  output logic [NUM_ROWS_WIDTH-1:0] frame_rows,
  output logic [NUM_COLS_WIDTH-1:0] frame_cols,
  output logic                      frame_err,
  output logic [15:0]               frame_count,
  output logic [31:0]               frame_checksum
);

  typedef enum logic [1:0] {IDLE, ARMED, IN_FRAME} state_t;

  state_t                    state;
  logic                      fv_prev, lv_prev;
  logic [NUM_COLS_WIDTH-1:0] col_cnt, first_len, col_cur;
  logic [NUM_ROWS_WIDTH-1:0] row_cnt, row_cur;
  logic                      err_acc;
  logic                      starting, running, cap, line_end, frame_end;
  logic                      col_sat, row_sat, len_bad;

  // The fv rise cycle already belongs to the frame, so counters read as zero there.
  always_comb begin
    starting  = enable && (state == ARMED) && fv && !fv_prev;
    running   = enable && (state == IN_FRAME);
    cap       = (starting || running) && fv && lv;
    line_end  = running && lv_prev && !(fv && lv);
    frame_end = running && !fv && fv_prev;
    col_cur   = starting ? '0 : col_cnt;
    row_cur   = starting ? '0 : row_cnt;
    col_sat   = &col_cur;
    row_sat   = &row_cnt;
    len_bad   = (row_cnt != '0) && (col_cnt != first_len);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fv_prev     <= 1'b0;
      lv_prev     <= 1'b0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      first_len   <= '0;
      err_acc     <= 1'b0;
      pix_dat     <= '0;
      pix_valid   <= 1'b0;
      pix_row     <= '0;
      pix_col     <= '0;
      pix_sof     <= 1'b0;
      frame_done  <= 1'b0;
      frame_rows  <= '0;
      frame_cols  <= '0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      fv_prev    <= fv;
      lv_prev    <= fv && lv;  // only lines inside fv can end
      pix_valid  <= 1'b0;
      pix_sof    <= 1'b0;
      frame_done <= 1'b0;

      if (!enable) state <= IDLE;
      else begin
        case (state)
          IDLE:     if (!fv) state <= ARMED;
          ARMED:    if (starting) state <= IN_FRAME;
          IN_FRAME: if (frame_end) state <= ARMED;
          default:  state <= IDLE;
        endcase
      end

      if (starting) begin
        col_cnt   <= '0;
        row_cnt   <= '0;
        first_len <= '0;
        err_acc   <= 1'b0;
      end

      if (cap) begin
        pix_dat   <= dat;
        pix_row   <= row_cur;
        pix_col   <= col_cur;
        pix_valid <= 1'b1;
        pix_sof   <= (row_cur == '0) && (col_cur == '0);
        if (col_sat) err_acc <= 1'b1;
        else         col_cnt <= col_cur + 1'b1;
      end

      if (line_end) begin
        if (row_cnt == '0)  first_len <= col_cnt;
        else if (len_bad)   err_acc   <= 1'b1;
        if (row_sat) err_acc <= 1'b1;
        else         row_cnt <= row_cnt + 1'b1;
        col_cnt <= '0;
      end

      // Statistics fold in the line closed on this same edge.
      if (frame_end) begin
        frame_rows  <= (line_end && !row_sat) ? row_cnt + 1'b1 : row_cnt;
        frame_cols  <= (line_end && row_cnt == '0) ? col_cnt : first_len;
        frame_err   <= err_acc | (line_end & (len_bad | row_sat));
        frame_count <= frame_count + 16'd1;
        frame_done  <= 1'b1;
      end
    end
  end

`ifdef IMAGER_RX_CHECKSUM_EN
  logic [31:0] sum_acc, sum_cur;
  assign sum_cur = starting ? '0 : sum_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_acc        <= '0;
      frame_checksum <= '0;
    end else begin
      if (starting) sum_acc <= '0;
      if (cap)      sum_acc <= sum_cur + {{(32-DATA_WIDTH){1'b0}}, dat};
      if (frame_end) frame_checksum <= sum_acc;
    end
  end
`else
  assign frame_checksum = '0;
`endif

endmodule

// File: tb/tb_imager_rx.sv
// Randomized frame stimulus checked against a frame-level reference model.
module tb_imager_rx;

  logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0, fv = 1'b0, lv = 1'b0;
  logic [9:0]  dat = '0;
  logic [9:0]  pix_dat;
  logic        pix_valid, pix_sof, frame_done, frame_err;
  logic [11:0] pix_row, pix_col, frame_rows, frame_cols;
  logic [15:0] frame_count;
  logic [31:0] frame_checksum;

  imager_rx dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .dat(dat), .fv(fv), .lv(lv),
    .pix_dat(pix_dat), .pix_valid(pix_valid), .pix_row(pix_row), .pix_col(pix_col),
    .pix_sof(pix_sof), .frame_done(frame_done), .frame_rows(frame_rows),
    .frame_cols(frame_cols), .frame_err(frame_err), .frame_count(frame_count),
    .frame_checksum(frame_checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] dat;
    int         row;
    int         col;
    bit         sof;
    int         cyc;
  } pix_t;

  typedef struct {
    int          rows;
    int          cols;
    bit          err;
    logic [15:0] cnt;
    logic [31:0] sum;
    int          cyc;
  } stat_t;

  pix_t  pq[$];
  stat_t sq[$];
  int    lens[$];
  int    checks = 0, errors = 0;
  int    exp_count = 0;
  bit    cap = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Outputs are compared on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    if (pix_valid) begin
      if (pq.size() == 0) chk("pix_spurious", 64'd1, 64'd0);
      else begin
        pix_t e;
        e = pq.pop_front();
        chk("pix", {29'd0, pix_dat, pix_row, pix_col, pix_sof},
                   {29'd0, e.dat, 12'(e.row), 12'(e.col), e.sof});
        chk("pix_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
    if (frame_done) begin
      if (sq.size() == 0) chk("done_spurious", 64'd1, 64'd0);
      else begin
        stat_t s;
        s = sq.pop_front();
        chk("stats", {23'd0, frame_rows, frame_cols, frame_err, frame_count},
                     {23'd0, 12'(s.rows), 12'(s.cols), s.err, s.cnt});
        chk("checksum", {32'd0, frame_checksum}, {32'd0, s.sum});
        chk("done_cyc", 64'(cyc), 64'(s.cyc));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pix"}, {27'd0, pix_dat, pix_row, pix_col, pix_valid, pix_sof, frame_done}, 64'd0);
    chk({tag, "_stats"}, {23'd0, frame_rows, frame_cols, frame_err, frame_count}, 64'd0);
    chk({tag, "_sum"}, {32'd0, frame_checksum}, 64'd0);
  endtask

  // abort_mode: 1 drops enable, 2 pulses reset, 3 raises enable, at pixel index abort_at.
  task automatic drive_frame(input int pre, input int gap_max, input bit drop, input int vb,
                             input int abort_at, input int abort_mode);
    bit          cp;
    int          idx, first, eff;
    bit          err;
    logic [31:0] sum;
    cp = cap; idx = 0; first = 0; err = 0; sum = '0;
    for (int i = 0; i < pre; i++) begin
      step; fv = 1'b1; lv = 1'b0;
    end
    for (int li = 0; li < lens.size(); li++) begin
      for (int p = 0; p < lens[li]; p++) begin
        step;
        if (idx == abort_at) begin
          if (abort_mode == 1) begin
            enable = 1'b0; cp = 0;
          end else if (abort_mode == 2) begin
            reset_n = 1'b0; cp = 0;
            pq.delete(); sq.delete(); exp_count = 0;
            #1;
            check_zero("reset_mid");
            reset_n = 1'b1;
          end else if (abort_mode == 3) begin
            enable = 1'b1;
          end
        end
        fv = 1'b1; lv = 1'b1; dat = 10'($urandom);
        if (cp) pq.push_back('{dat, li, (p > 4095) ? 4095 : p, idx == 0, cyc + 1});
        sum = sum + {22'd0, dat};
        idx++;
      end
      eff = (lens[li] > 4095) ? 4095 : lens[li];
      if (li == 0) first = eff;
      else if (eff != first) err = 1;
      if (lens[li] > 4095) err = 1;
      if (!(drop && li == lens.size() - 1)) begin
        for (int g = 0; g < $urandom_range(gap_max, 1); g++) begin
          step; lv = 1'b0;
        end
      end
    end
    step; fv = 1'b0; lv = 1'b0;
    if (cp) begin
      exp_count++;
`ifdef IMAGER_RX_CHECKSUM_EN
      sq.push_back('{lens.size(), first, err, 16'(exp_count), sum, cyc + 1});
`else
      sq.push_back('{lens.size(), first, err, 16'(exp_count), 32'd0, cyc + 1});
`endif
    end
    for (int i = 1; i < vb; i++) step;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step;
    check_zero("reset");
    reset_n = 1'b1;
    step;

    // Enable raised mid-frame: nothing from that frame, the next one is frame 1.
    enable = 1'b0; cap = 0;
    lens = '{6, 6, 6};
    drive_frame(2, 3, 0, 2, 7, 3);
    cap = 1;
    lens = '{6, 6, 6, 6};
    drive_frame(2, 4, 0, 3, -1, 0);
    chk("count_after_midenable", 64'(frame_count), 64'd1);

    // Regular 4x6 frames, back to back with one blank cycle.
    for (int f = 0; f < 3; f++) drive_frame(2, 4, 0, 1, -1, 0);
    step; step;

    // One short line in the middle.
    lens = '{6, 6, 5, 6};
    drive_frame(1, 2, 0, 2, -1, 0);

    // Random geometry, sometimes ragged, sometimes lv/fv dropping together.
    for (int f = 0; f < 12; f++) begin
      int n, base;
      n = $urandom_range(5, 1);
      base = $urandom_range(8, 1);
      lens.delete();
      for (int l = 0; l < n; l++)
        lens.push_back(($urandom_range(3, 0) == 0) ? $urandom_range(8, 1) : base);
      drive_frame($urandom_range(3, 1), 3, 1'($urandom_range(1, 0)), $urandom_range(3, 1), -1, 0);
    end

    // Frame with no active pixels.
    lens.delete();
    drive_frame(5, 1, 0, 2, -1, 0);

    // Enable dropped mid-line, then restored between frames.
    lens = '{6, 6, 6};
    drive_frame(2, 3, 0, 2, 8, 1);
    enable = 1'b1;
    lens = '{6, 6, 6, 6};
    drive_frame(2, 3, 0, 2, -1, 0);

    // Reset pulsed mid-line; next frame counts from one again.
    lens = '{6, 6, 6};
    drive_frame(2, 3, 0, 2, 9, 2);
    lens = '{6, 6, 6, 6};
    drive_frame(2, 3, 0, 3, -1, 0);
    chk("count_after_reset", 64'(frame_count), 64'd1);

    // Column counter saturation.
    lens = '{4100};
    drive_frame(2, 2, 0, 3, -1, 0);

    repeat (4) step;
    chk("pix_queue_empty", 64'(pq.size()), 64'd0);
    chk("stat_queue_empty", 64'(sq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imager_rx.md
# imager_rx

Frame/line capture receiver for the parallel pixel bus (`dat`/`fv`/`lv`) driven by the simulated imager or a real sensor front end.
- Samples the bus and re-emits each active pixel with its row and column coordinates.
- Measures frame geometry and checks that line lengths are consistent.
- Produces per-frame statistics with a one-cycle `frame_done` strobe.
- Sits at the sensor-facing edge of the capture path, ahead of buffering and host-readout logic.

## Interface
- `DATA_WIDTH`, 10, pixel width.
- `NUM_ROWS_WIDTH`, 12, width of row counters and row outputs.
- `NUM_COLS_WIDTH`, 12, width of column counters and column outputs.

- `clk` in 1: pixel clock. All inputs are sampled on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: receiver runs when high.
- `dat` in DATA_WIDTH: pixel data.
- `fv` in 1: frame valid.
- `lv` in 1: line valid.
- `pix_dat` out DATA_WIDTH: captured pixel.
- `pix_valid` out 1: `pix_*` outputs hold an active pixel.
- `pix_row` out NUM_ROWS_WIDTH: row index of the pixel, 0-based.
- `pix_col` out NUM_COLS_WIDTH: column index of the pixel, 0-based.
- `pix_sof` out 1: first pixel of a frame. Qualified by `pix_valid`.
- `frame_done` out 1: one-cycle pulse when a complete frame ends.
- `frame_rows` out NUM_ROWS_WIDTH: line count of the last completed frame.
- `frame_cols` out NUM_COLS_WIDTH: length of the first line of the last completed frame.
- `frame_err` out 1: set if any line length mismatched or any counter saturated in the last completed frame.
- `frame_count` out 16: number of completed frames, wraps.
- `frame_checksum` out 32: checksum of the last completed frame (see Configuration).

## Operation
- Internal state registers: `fv_prev` and `lv_prev` (previous samples), `col_cnt`, `row_cnt`, `first_len`, `err_acc`, `sum_acc`.
- FSM states:
  - IDLE: receiver inactive.
  - ARMED: waiting for a frame start.
  - IN_FRAME: capturing a frame.
- FSM transitions:
  - `enable`=0 forces IDLE from any state. No `frame_done` is generated and accumulators are not latched.
  - IDLE→ARMED when `enable`=1 and `fv`=0 are sampled. A frame already in progress at enable is discarded; there is no partial capture.
  - ARMED→IN_FRAME on a sampled `fv` rise. This clears `col_cnt`, `row_cnt`, `err_acc`, `sum_acc` and `first_len`.
  - IN_FRAME→ARMED on a sampled `fv` fall (`fv`=0, `fv_prev`=1).
- Pixel capture in IN_FRAME:
  - Each cycle with `lv`=1 and `fv`=1 registers `pix_dat<=dat`, `pix_row<=row_cnt`, `pix_col<=col_cnt` and `pix_valid<=1`, then increments `col_cnt`.
  - `pix_sof`=1 on the first such pixel of the frame.
- Line end is `lv` fall (`lv`=0, `lv_prev`=1), or an `fv` fall while `lv_prev`=1. A simultaneous `lv`/`fv` drop counts as a line end.
- At line end:
  - If `row_cnt`==0, `first_len<=col_cnt`; otherwise a mismatch between `col_cnt` and `first_len` sets `err_acc`.
  - Then `row_cnt++` and `col_cnt<=0`.
- `lv`=1 while `fv`=0, or any input activity in IDLE/ARMED, is ignored and `pix_valid` stays 0.
- Saturation: `col_cnt` and `row_cnt` saturate at all-ones and set `err_acc`. A saturated column count must not wrap `pix_col`.
- At `fv` fall:
  - `frame_rows<=row_cnt`, including the line closed on the same edge.
  - `frame_cols<=first_len`, or the closing line length if it is the only line.
  - `frame_err<=err_acc`, `frame_checksum<=sum_acc`, `frame_count++`, `frame_done<=1` for one cycle.
- A frame containing zero active pixels still completes, with `frame_rows`=0 and `frame_cols`=0.

## Timing
- Reset values: all outputs are 0 and the FSM is in IDLE.
- Pixel latency is 1 cycle: a pixel sampled at edge k is visible on `pix_*` after edge k.
- `frame_done` is high for exactly the cycle after the edge that samples `fv`=0. Statistics update on that same edge and hold until the next `frame_done`.
- Back-to-back frames: `fv` low for 1 cycle is sufficient. The next frame's `fv` rise may be sampled while `frame_done` is high.
- Reset mid-frame clears everything immediately. The next capture requires `fv`=0 to be seen first.

## Configuration
- `IMAGER_RX_CHECKSUM_EN` defined:
  - `sum_acc` adds each captured `pix_dat`, zero-extended, mod 2^32.
  - `frame_checksum` is latched at frame end.
- `IMAGER_RX_CHECKSUM_EN` undefined:
  - The accumulator is not built and `frame_checksum` is tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Imager mode 1, active 4 rows × 6 cols, virtual 2 rows × 4 cols -> `frame_done` every 60 cycles; `frame_rows`=4, `frame_cols`=6, `frame_err`=0. With checksum enabled, `frame_checksum`=36.
- Same geometry, imager mode 2 -> `frame_checksum`=108; `pix_col` runs 0..5 per line; `pix_sof` is asserted once per frame at row 0, col 0.
- Hand-driven frame with line lengths 6,6,5,6 -> `frame_err`=1, `frame_rows`=4, `frame_cols`=6.
- `enable` raised mid-frame -> no pixels and no `frame_done` for that frame; the next full frame is captured and `frame_count` is 1.
- `enable` dropped, then separately `reset_n` pulsed, mid-line -> no `frame_done`; outputs are 0 after reset; the next full frame is captured correctly.
- Line of 4100 pixels with `NUM_COLS_WIDTH`=12 -> `pix_col` holds at 4095 and `frame_err`=1.
